// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin share of one 16-to-32 immediate extend unit
// between the ALU operand path (req0) and the branch-offset path (req1).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/ready          requester 0 handshake
//   req0_imm16/extop/tag      requester 0 operands (extop 1 = sign extend)
//   req1_valid/ready          requester 1 handshake
//   req1_imm16/extop/tag      requester 1 operands
//   out_valid/ready           result handshake toward the consumer
//   out_data/src/tag          extended immediate, source index, request tag
module ext_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_imm16,
    input  logic             req0_extop,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_imm16,
    input  logic             req1_extop,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag
);

    logic             prio;
    logic             free;
    logic             gnt0;
    logic             gnt1;
    logic             xfer;
    logic [15:0]      sel_imm;
    logic             sel_extop;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      ext_data;

    // The output slot can take a new result when empty or being drained.
    assign free = !out_valid || out_ready;

    // Grants already include the request valid, so a grant is a transfer.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (free && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !prio;
                gnt1 = prio;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 || gnt1;

    always_comb begin
        sel_imm   = req0_imm16;
        sel_extop = req0_extop;
        sel_tag   = req0_tag;
        if (gnt1) begin
            sel_imm   = req1_imm16;
            sel_extop = req1_extop;
            sel_tag   = req1_tag;
        end
    end

    assign ext_data = sel_extop ? {{16{sel_imm[15]}}, sel_imm}
                                : {16'h0000, sel_imm};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_tag   <= '0;
            prio      <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ext_data;
            out_src   <= gnt1;
            out_tag   <= sel_tag;
            // Favour the other requester after every transfer.
            prio      <= gnt0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: directed and randomized checks of ext_arbiter
// against a behavioural reference model.
module tb_ext_arbiter;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [15:0]      req0_imm16;
    logic             req0_extop;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [15:0]      req1_imm16;
    logic             req1_extop;
    logic [TAG_W-1:0] req1_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_src;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    ext_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm16 (req0_imm16),
        .req0_extop (req0_extop),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm16 (req1_imm16),
        .req1_extop (req1_extop),
        .req1_tag   (req1_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_tag    (out_tag)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: held result and the requester currently favoured.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_tag;
    int          m_prio;
    int          m_winner;
    logic        last_r0;
    logic        last_r1;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic sx);
        if (sx) return 32'($signed(imm));
        return 32'(imm);
    endfunction

    // Who should win this cycle: -1 none, else requester index.
    function automatic int pick();
        bit any_free;
        any_free = !m_valid || out_ready;
        if (rst || !any_free) return -1;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Inputs are set just after a rising edge; check, clock, update model.
    task automatic step();
        #3;
        m_winner = pick();
        last_r0 = req0_ready;
        last_r1 = req1_ready;
        chk("req0_ready", 32'(req0_ready), 32'(m_winner == 0));
        chk("req1_ready", 32'(req1_ready), 32'(m_winner == 1));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", out_data, m_data);
        chk("out_src", 32'(out_src), 32'(m_src));
        chk("out_tag", 32'(out_tag), 32'(m_tag));
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_data  = 0;
            m_src   = 0;
            m_tag   = 0;
            m_prio  = 0;
        end else if (m_winner == 0) begin
            m_valid = 1;
            m_data  = extend(req0_imm16, req0_extop);
            m_src   = 0;
            m_tag   = int'(req0_tag);
            m_prio  = 1;
        end else if (m_winner == 1) begin
            m_valid = 1;
            m_data  = extend(req1_imm16, req1_extop);
            m_src   = 1;
            m_tag   = int'(req1_tag);
            m_prio  = 0;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_src = 0; m_tag = 0; m_prio = 0;
        rst = 1;
        req0_valid = 1; req0_imm16 = 16'h1111; req0_extop = 0; req0_tag = 4'd7;
        req1_valid = 1; req1_imm16 = 16'h2222; req1_extop = 1; req1_tag = 4'd8;
        out_ready = 1;
        @(posedge clk);
        #1;

        // Reset held two cycles with both requesters valid.
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_ready", {30'd0, last_r1, last_r0}, 32'd0);
        rst = 0;
        step();
        chk("first_grant_r0", 32'(last_r0), 32'd1);
        req1_valid = 0;
        req0_valid = 0;
        step();

        // Sign extend via requester 0.
        req0_valid = 1; req0_imm16 = 16'h8001; req0_extop = 1; req0_tag = 4'd3;
        step();
        req0_valid = 0;
        chk("sx_data", out_data, 32'hFFFF8001);
        chk("sx_src", 32'(out_src), 32'd0);
        chk("sx_tag", 32'(out_tag), 32'd3);

        // Zero extend via requester 1.
        req1_valid = 1; req1_imm16 = 16'h8001; req1_extop = 0; req1_tag = 4'd5;
        step();
        req1_valid = 0;
        chk("zx_data", out_data, 32'h00008001);
        chk("zx_src", 32'(out_src), 32'd1);
        chk("zx_tag", 32'(out_tag), 32'd5);

        // Continuous contention alternates 0,1,0,1.
        req0_valid = 1; req0_tag = 4'd1;
        req1_valid = 1; req1_tag = 4'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_one_ready", 32'(last_r0) + 32'(last_r1), 32'd1);
            chk("alt_src", 32'(out_src), 32'(i % 2));
            chk("alt_tag", 32'(out_tag), 32'((i % 2) + 1));
        end
        req0_valid = 0;
        req1_valid = 0;

        // Backpressure with requester 0 waiting.
        req0_valid = 1; req0_imm16 = 16'h1234; req0_extop = 0;
        step();
        req0_imm16 = 16'h5678; req0_extop = 1; req0_tag = 4'd9;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_no_ready", 32'(last_r0), 32'd0);
            chk("bp_hold", out_data, 32'h00001234);
        end
        out_ready = 1;
        step();
        chk("bp_release_ready", 32'(last_r0), 32'd1);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_new", out_data, 32'h00005678);
        req0_valid = 0;
        out_ready = 0;
        step();

        // Reset mid-stall: prio is 1 here, reset returns it to 0.
        rst = 1;
        step();
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        rst = 0;
        req0_valid = 1;
        req1_valid = 1;
        out_ready = 1;
        step();
        chk("rst_stall_r0", 32'(last_r0), 32'd1);

        // Randomized traffic obeying the hold-until-accepted rule.
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid || last_r0 || rst) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_imm16 = 16'($urandom);
                req0_extop = 1'($urandom);
                req0_tag   = TAG_W'($urandom);
            end
            if (!req1_valid || last_r1 || rst) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_imm16 = 16'($urandom);
                req1_extop = 1'($urandom);
                req1_tag   = TAG_W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
